mux_sel_arbiter: RTL
====================

Name: mux_sel_arbiter

Overview:
- Round-robin select generator sitting directly upstream of the 4-to-1 mux.
- Takes four channel request lines and drives the mux select plus a one-hot grant back to the requesters.
- Each granted channel holds the mux for a programmable dwell time. Empty channels are skipped.
- A scan mode rotates the select unconditionally, as used for bring-up.

Parameters:
- DWELL, 4: maximum cycles a grant is held while its request stays high; legal range 1..255.
- CW, 8: dwell counter width; must satisfy 2**CW > DWELL.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  4  channel requests; bit i requests mux input i (0=a, 1=b, 2=c, 3=d).
- scan  input  1  1 = ignore req and rotate sel 0,1,2,3,0... every DWELL cycles.
- sel  output  2  mux select, registered.
- gnt  output  4  one-hot grant, registered; all zeros when nothing is granted.
- valid  output  1  1 when sel addresses a granted or scanned channel.

Behaviour:
- Clock and reset:
  - One clock (clk). Reset rst is asynchronous and active-high.
  - All state is updated on the rising edge of clk.
- Reset values:
  - sel=2'b00, gnt=4'b0000, valid=0, state=IDLE, cnt=0.
  - ptr (last granted index) = 3, so channel 0 has first priority.
- Pick function:
  - Searches req starting at index (ptr+1) mod 4 and wraps around.
  - Returns the first set index and a found flag.
- State IDLE (valid=0, gnt=0, sel holds its last value):
  - scan=1: next state SCAN, sel=0, cnt=0.
  - Otherwise, if found: next state GRANT, sel=idx, gnt=1<<idx, ptr=idx, cnt=0.
  - Latency: req rising in cycle N gives gnt/valid high in cycle N+1.
- State GRANT (valid=1):
  - Release occurs when req[sel]=0 (sampled) or cnt==DWELL-1.
  - No release: cnt increments.
  - Release with found over req masked by ~gnt: switch directly to the new index. No idle cycle, cnt=0.
  - Release, no other requester, own request still high (dwell expiry only): re-grant the same channel, cnt=0.
  - Release otherwise: next state IDLE, gnt=0, valid=0.
  - scan=1 takes priority over all the above: next state SCAN, sel=0, gnt=0, cnt=0.
- State SCAN (valid=1, gnt=0):
  - sel advances by 1 (mod 4, 3 wraps to 0) when cnt==DWELL-1. cnt then returns to 0; otherwise cnt increments.
  - scan=0: next state IDLE; ptr is unchanged.
- DWELL=1:
  - Every GRANT cycle is a release cycle.
  - Concurrent requesters rotate every cycle.
  - SCAN advances sel every cycle.
- Simultaneous events:
  - A request dropping in the same cycle as dwell expiry is treated as a single release.
  - Requests arriving mid-grant are not serviced before release.
- Outputs:
  - gnt is always one-hot or zero and is never multi-hot.
  - valid==|gnt, except in SCAN.
- Reset mid-grant or mid-scan: outputs return to reset values immediately (asynchronous), without waiting for a clock edge.

Decomposition:
- Package mux_sel_pkg:
  - NCH=4.
  - State encoding IDLE=2'd0, GRANT=2'd1, SCAN=2'd2.
  - Width constant SELW=2.
- Sub-module rr_pick:
  - Combinational: inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and found.
  - Instantiated twice: full req for IDLE, req & ~gnt for GRANT release.
- Top mux_sel_arbiter contains the FSM, the dwell counter and ptr.

Test Plan:
- Reset and idle: rst=1 then rst=0 with req=0000.
  - sel=00, gnt=0000 and valid=0 for 20 cycles.
- Single requester: req=0100 from cycle 5.
  - Cycle 6: gnt=0100, sel=10, valid=1.
  - Re-granted every 4 cycles (DWELL=4) and stays 0100.
  - req dropped at cycle 15: gnt=0000 at cycle 16.
- Round robin: req=1111 continuously.
  - Grants 0001,0010,0100,1000,0001..., each held exactly 4 cycles, no gaps.
  - sel follows 00,01,10,11.
- Skip and early release: req=1001.
  - Grant 0001 for 4 cycles, then 1000.
  - Drop req[3] after 2 cycles of its grant: gnt=0001 on the next cycle.
- Scan mode: scan=1 during a grant of channel 2.
  - Next cycle: gnt=0000, valid=1, sel=00; then 01,10,11,00 every 4 cycles.
  - scan=0 then returns to IDLE and arbitration resumes from ptr+1=3.
- Async reset mid-grant: assert rst between clock edges during gnt=0010.
  - Outputs go to reset values before the next edge.
  - After release, req=1111 grants 0001 first.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg
// Shared constants, FSM state encoding and a one-hot helper for the
// round-robin mux select arbiter.
//   NCH     : number of mux channels
//   SELW    : width of the mux select / channel index
//   state_t : arbiter FSM states
package mux_sel_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SCAN  = 2'd2
    } state_t;

    // Converts a channel index into its one-hot grant vector.
    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] i);
        logic [NCH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin search. Looks for the first set request bit,
// starting one position after ptr and wrapping around, so that ptr itself
// is considered last.
//   req   : request vector to search
//   ptr   : index of the most recently granted channel
//   idx   : index of the chosen channel (0 when nothing is found)
//   found : 1 when any bit of req is set
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [SELW-1:0] cand;

    // The final iteration wraps cand back onto ptr, giving the previous
    // owner lowest priority.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = ptr + SELW'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Round-robin select generator feeding a 4-to-1 mux. Each granted channel
// holds the mux for up to DWELL cycles while its request stays high; empty
// channels are skipped. Scan mode ignores requests and rotates sel every
// DWELL cycles for bring-up.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   req   : channel requests, bit i asks for mux input i
//   scan  : 1 = rotate sel unconditionally
//   sel   : registered mux select
//   gnt   : registered one-hot grant, zero when nothing is granted
//   valid : sel addresses a granted or scanned channel
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic            scan,
    output logic [SELW-1:0] sel,
    output logic [NCH-1:0]  gnt,
    output logic            valid
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic [SELW-1:0] idle_idx, rel_idx;
    logic            idle_found, rel_found;
    logic            release_now;

    // Fresh arbitration from IDLE looks at every request.
    rr_pick u_pick_idle (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (idle_idx),
        .found (idle_found)
    );

    // On release the current owner is masked out so another requester
    // wins whenever one exists.
    rr_pick u_pick_rel (
        .req   (req & ~gnt_q),
        .ptr   (ptr_q),
        .idx   (rel_idx),
        .found (rel_found)
    );

    // A dropped request and dwell expiry in the same cycle collapse into
    // one release.
    assign release_now = !req[sel_q] || (cnt_q == CNT_LAST);

    // Register stage. ptr resets to the last channel so channel 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= SELW'(NCH - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic. Scan always wins; in GRANT a release hands over
    // directly to the next requester so there is no idle gap between owners.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (scan) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else if (idle_found) begin
                    state_d = GRANT;
                    sel_d   = idle_idx;
                    gnt_d   = onehot(idle_idx);
                    ptr_d   = idle_idx;
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                if (scan) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (!release_now) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (rel_found) begin
                    sel_d = rel_idx;
                    gnt_d = onehot(rel_idx);
                    ptr_d = rel_idx;
                    cnt_d = '0;
                end else if (req[sel_q]) begin
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end

            SCAN: begin
                gnt_d = '0;
                if (!scan) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    sel_d = sel_q + 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign sel   = sel_q;
    assign gnt   = gnt_q;
    assign valid = (state_q != IDLE);

endmodule
